ex_stage: RTL and testbench
===========================

// Module: ex_stage
// PURPOSE
//  Execute stage of the 5-stage MIPS pipeline, directly downstream of the decode stage.
//  - Registers id_to_ex_bus.
//  - Performs the ALU operation and issues the data-SRAM request.
//  - Forwards its result back to decode and passes the result to MEM.
//  - Holds the HI/LO registers and a 32-iteration divider; the divider stalls the pipe while busy.
// PARAMETERS
//  ID_TO_EX_WD   159  width of decode->execute bus
//  EX_TO_MEM_WD  76   width of execute->memory bus
//  EX_TO_ID_WD   38   width of forwarding bus {rf_we, rf_waddr, result}
//  DIV_ITER      32   divider iterations, one quotient bit per cycle
// PORTS
//  clk               in   1    single clock, rising edge
//  rst               in   1    asynchronous, active-high reset
//  stall             in   6    stall vector from the stall controller; Stop=1; [2]=ID/EX, [3]=EX/MEM
//  id_to_ex_bus      in   159  {pc,inst,alu_op[11:0],src1[2:0],src2[3:0],ram_en,ram_wen[3:0],rf_we,waddr,sel_rf_res,rdata1,rdata2}
//  ex_to_mem_bus     out  76   {pc,ram_en,ram_wen,sel_rf_res,rf_we,waddr,ex_result}
//  ex_to_id_bus      out  38   {rf_we,waddr,ex_result}; decode uses waddr at [36:32]
//  is_lw             out  1    EX holds a load (ram_en & ~|ram_wen)
//  stallreq_from_ex  out  1    divider-busy stall request
//  data_sram_en      out  1    data-SRAM enable
//  data_sram_wen     out  4    data-SRAM byte write enable
//  data_sram_addr    out  32   = ALU sum
//  data_sram_wdata   out  32   = rdata2
// BEHAVIOUR
//  - Reset (async): bus register, HI, LO, FSM and counter all clear; FSM=IDLE.
//    All outputs are 0 after reset (bubble).
//  - Bus register update, in priority order:
//    - rst: clear.
//    - stall[2]=1 & stall[3]=0: load zero (bubble).
//    - stall[2]=0: load id_to_ex_bus.
//    - Otherwise: hold.
//  - ALU operand src1 (one-hot select): rs | pc | {27'b0,sa}.
//  - ALU operand src2 (one-hot select): rt | sign-ext imm | 32'd8 | zero-ext imm.
//  - ALU ops (one-hot alu_op; a zero vector yields result 0):
//    - add/sub: mod 2^32.
//    - sltu: unsigned compare, result 1 or 0.
//    - slt: signed compare.
//    - and/or/xor/nor: bitwise.
//    - sll/srl/sra: shift src2 by src1[4:0].
//    - lui: {src2[15:0],16'b0}.
//  - Decoding from the inst field (opcode 0): mfhi 010000, mthi 010001, mflo 010010, mtlo 010011, div 011010, divu 011011.
//  - mfhi/mflo: ex_result = HI/LO and rf_we=1 to rd. This overrides the bus rf fields.
//  - mthi/mtlo: HI/LO <= rdata1 at the clock edge when stall[2]=0.
//  - ex_result = ALU result, or the HI/LO read value. The result is available combinationally, with zero added latency.
//  - Divider FSM:
//    - IDLE: a div/divu in EX latches operand magnitudes -> BUSY, counter=0; stallreq=1 in this cycle.
//    - BUSY: one restoring shift-subtract step per cycle; stallreq=1.
//      After counter reaches DIV_ITER-1 -> DONE.
//    - DONE: HI/LO written at the end of this cycle; stallreq=0 -> IDLE.
//      The same instruction does not re-trigger.
//    - A div occupies EX for 34 cycles: 33 stalled plus the DONE cycle.
//  - Division sign and divide-by-zero rules:
//    - Signed div: quotient is negated when operand signs differ. The remainder takes the dividend's sign.
//    - Divide by zero: LO=32'hFFFF_FFFF, HI=dividend. The divide still takes the full latency.
//  - mfhi directly after div sees the new HI; no extra stall is required.
//  - An async reset mid-division aborts the divide: FSM=IDLE, stallreq=0, HI/LO=0.
//  - stallreq_from_ex is never asserted for a bubble.
// CONFIGURATION
//  - EX_DIV_EN defined: divider FSM, div/divu and stallreq_from_ex are implemented as above.
//  - EX_DIV_EN undefined:
//    - div/divu execute as nops; HI/LO are unchanged.
//    - stallreq_from_ex is tied to 0 and no FSM exists.
//    - mfhi/mflo/mthi/mtlo are still supported.
// TESTING
//  1. Issue addiu rs=5, imm=-3 (src1=rs, src2=sign-ext imm, op_add) -> ex_result=2, ex_to_id_bus={1,rt,32'd2} in the same cycle.
//  2. Issue sw rdata1=0x1000, imm=8, rdata2=0xAB -> data_sram_en=1, wen=4'hF, addr=0x1008, wdata=0xAB, is_lw=0.
//     Then issue lw -> is_lw=1, wen=0.
//  3. Issue div 7/-2 (EX_DIV_EN) -> stallreq high for 33 cycles, then LO=0xFFFF_FFFD (-3), HI=1.
//     A following mflo returns 0xFFFF_FFFD.
//  4. Issue divu 0xFFFF_FFFF/0 -> LO=0xFFFF_FFFF, HI=0xFFFF_FFFF after the full latency.
//  5. Assert rst asynchronously at BUSY cycle 10 -> stallreq drops immediately, HI=LO=0.
//     A following div starts a fresh 33-cycle stall.
//  6. Apply stall[2]=1, stall[3]=0 -> next cycle all outputs 0.
//     Apply stall[2]=1, stall[3]=1 -> bus held, outputs unchanged.

Source files
------------

// File: rtl/ex_stage.sv
// ex_stage: execute stage of the 5-stage MIPS pipeline (ALU, data-SRAM request, forwarding, HI/LO).
// Optional feature macro EX_DIV_EN: 32-iteration restoring divider for div/divu with pipeline stall request.
module ex_stage #(
  parameter int ID_TO_EX_WD  = 159,
  parameter int EX_TO_MEM_WD = 76,
  parameter int EX_TO_ID_WD  = 38,
  parameter int DIV_ITER     = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [5:0]              stall,
  input  logic [ID_TO_EX_WD-1:0]  id_to_ex_bus,
  output logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
  output logic [EX_TO_ID_WD-1:0]  ex_to_id_bus,
  output logic                    is_lw,
  output logic                    stallreq_from_ex,
  output logic                    data_sram_en,
  output logic [3:0]              data_sram_wen,
  output logic [31:0]             data_sram_addr,
  output logic [31:0]             data_sram_wdata
);

  localparam int unsigned DIV_LAST = DIV_ITER - 1;

  logic [ID_TO_EX_WD-1:0] bus_q, bus_d;
  logic [31:0]            hi_q, hi_d, lo_q, lo_d;

  logic [31:0] pc, inst, rdata1, rdata2;
  logic [11:0] alu_op;
  logic [2:0]  sel_src1;
  logic [3:0]  sel_src2, ram_wen;
  logic        ram_en, rf_we, sel_rf_res;
  logic [4:0]  waddr;

  assign {pc, inst, alu_op, sel_src1, sel_src2, ram_en, ram_wen,
          rf_we, waddr, sel_rf_res, rdata1, rdata2} = bus_q;

  // alu_op one-hot: [11]add [10]sub [9]slt [8]sltu [7]and [6]nor [5]or [4]xor [3]sll [2]srl [1]sra [0]lui
  logic is_special, is_mfhi, is_mthi, is_mflo, is_mtlo, is_div, is_divu;
  assign is_special = (inst[31:26] == 6'b000000);
  assign is_mfhi    = is_special & (inst[5:0] == 6'b010000);
  assign is_mthi    = is_special & (inst[5:0] == 6'b010001);
  assign is_mflo    = is_special & (inst[5:0] == 6'b010010);
  assign is_mtlo    = is_special & (inst[5:0] == 6'b010011);
  assign is_div     = is_special & (inst[5:0] == 6'b011010);
  assign is_divu    = is_special & (inst[5:0] == 6'b011011);

  logic [31:0] src1, src2, alu_sum, alu_res;
  logic        lt_s, lt_u;

  always_comb begin
    src1 = ({32{sel_src1[0]}} & rdata1)
         | ({32{sel_src1[1]}} & pc)
         | ({32{sel_src1[2]}} & {27'b0, inst[10:6]});
    src2 = ({32{sel_src2[0]}} & rdata2)
         | ({32{sel_src2[1]}} & {{16{inst[15]}}, inst[15:0]})
         | ({32{sel_src2[2]}} & 32'd8)
         | ({32{sel_src2[3]}} & {16'b0, inst[15:0]});
    alu_sum = src1 + src2;
    lt_s    = $signed(src1) < $signed(src2);
    lt_u    = src1 < src2;
    alu_res = ({32{alu_op[11]}} & alu_sum)
            | ({32{alu_op[10]}} & (src1 - src2))
            | ({32{alu_op[9]}}  & {31'b0, lt_s})
            | ({32{alu_op[8]}}  & {31'b0, lt_u})
            | ({32{alu_op[7]}}  & (src1 & src2))
            | ({32{alu_op[6]}}  & ~(src1 | src2))
            | ({32{alu_op[5]}}  & (src1 | src2))
            | ({32{alu_op[4]}}  & (src1 ^ src2))
            | ({32{alu_op[3]}}  & (src2 << src1[4:0]))
            | ({32{alu_op[2]}}  & (src2 >> src1[4:0]))
            | ({32{alu_op[1]}}  & 32'($signed(src2) >>> src1[4:0]))
            | ({32{alu_op[0]}}  & {src2[15:0], 16'b0});
  end

  logic [31:0] ex_result;
  logic        rf_we_o;
  logic [4:0]  waddr_o;

  always_comb begin
    ex_result = alu_res;
    rf_we_o   = rf_we;
    waddr_o   = waddr;
    if (is_mfhi) begin
      ex_result = hi_q;
      rf_we_o   = 1'b1;
      waddr_o   = inst[15:11];
    end else if (is_mflo) begin
      ex_result = lo_q;
      rf_we_o   = 1'b1;
      waddr_o   = inst[15:11];
    end
  end

  assign ex_to_mem_bus   = {pc, ram_en, ram_wen, sel_rf_res, rf_we_o, waddr_o, ex_result};
  assign ex_to_id_bus    = {rf_we_o, waddr_o, ex_result};
  assign is_lw           = ram_en & ~|ram_wen;
  assign data_sram_en    = ram_en;
  assign data_sram_wen   = ram_wen;
  assign data_sram_addr  = alu_sum;
  assign data_sram_wdata = rdata2;

  always_comb begin
    if (!stall[2])      bus_d = id_to_ex_bus;
    else if (!stall[3]) bus_d = '0;
    else                bus_d = bus_q;
  end

`ifdef EX_DIV_EN
  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} div_state_e;
  localparam int CNT_W = $clog2(DIV_ITER);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
  logic             q_neg_q, q_neg_d, r_neg_q, r_neg_d, dz_q, dz_d;
  logic [33:0]      trial;
  logic [31:0]      q_fin, r_fin;
  logic             div_any;

  assign div_any = is_div | is_divu;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    q_neg_d = q_neg_q;
    r_neg_d = r_neg_q;
    dz_d    = dz_q;
    trial   = {1'b0, rem_q, quo_q[31]} - {2'b00, dvs_q};
    case (state_q)
      S_IDLE: if (div_any) begin
        state_d = S_BUSY;
        cnt_d   = '0;
        rem_d   = '0;
        quo_d   = (is_div & rdata1[31]) ? -rdata1 : rdata1;
        dvs_d   = (is_div & rdata2[31]) ? -rdata2 : rdata2;
        q_neg_d = is_div & (rdata1[31] ^ rdata2[31]);
        r_neg_d = is_div & rdata1[31];
        dz_d    = (rdata2 == '0);
      end
      S_BUSY: begin
        // Divisor 0 never borrows: quotient fills with ones and rem ends as |dividend|
        if (trial[33]) begin
          rem_d = {rem_q[30:0], quo_q[31]};
          quo_d = {quo_q[30:0], 1'b0};
        end else begin
          rem_d = trial[31:0];
          quo_d = {quo_q[30:0], 1'b1};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(DIV_LAST)) state_d = S_DONE;
      end
      S_DONE: if (!stall[2]) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign q_fin            = q_neg_q ? -quo_q : quo_q;
  assign r_fin            = r_neg_q ? -rem_q : rem_q;
  assign stallreq_from_ex = (state_q == S_BUSY) | ((state_q == S_IDLE) & div_any);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      q_neg_q <= q_neg_d;
      r_neg_q <= r_neg_d;
      dz_q    <= dz_d;
    end
  end
`else
  assign stallreq_from_ex = 1'b0;
`endif

  // HI/LO update at the DONE edge, so an mfhi/mflo arriving next reads the new value
  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (!stall[2] && is_mthi) hi_d = rdata1;
    if (!stall[2] && is_mtlo) lo_d = rdata1;
`ifdef EX_DIV_EN
    if (state_q == S_DONE) begin
      hi_d = r_fin;
      lo_d = dz_q ? '1 : q_fin;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus_q <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
    end else begin
      bus_q <= bus_d;
      hi_q  <= hi_d;
      lo_q  <= lo_d;
    end
  end

  logic unused_ok;
`ifdef EX_DIV_EN
  assign unused_ok = ^{stall[5:4], stall[1:0], inst[25:16]};
`else
  assign unused_ok = ^{stall[5:4], stall[1:0], inst[25:16], is_div, is_divu, DIV_LAST[0]};
`endif

endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: directed scoreboard bench for ex_stage; divider expectations follow EX_DIV_EN.
module tb_ex_stage;

`ifdef EX_DIV_EN
  localparam bit DIV = 1'b1;
`else
  localparam bit DIV = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [5:0]   stall, stall_man;
  logic [158:0] id_to_ex_bus;
  logic [75:0]  ex_to_mem_bus;
  logic [37:0]  ex_to_id_bus;
  logic         is_lw, stallreq_from_ex, data_sram_en;
  logic [3:0]   data_sram_wen;
  logic [31:0]  data_sram_addr, data_sram_wdata;

  int unsigned n_chk = 0, n_pass = 0, n_fail = 0;

  typedef struct packed {
    logic [75:0] mem;
    logic [37:0] id;
    logic [69:0] sram;
    logic        sreq;
  } exp_t;

  exp_t  sb[$];
  string tq[$];
  exp_t  last_exp;

  always #5 clk = ~clk;
  assign stall = stall_man | (stallreq_from_ex ? 6'b001111 : 6'b000000);

  ex_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .id_to_ex_bus(id_to_ex_bus),
    .ex_to_mem_bus(ex_to_mem_bus), .ex_to_id_bus(ex_to_id_bus), .is_lw(is_lw),
    .stallreq_from_ex(stallreq_from_ex), .data_sram_en(data_sram_en),
    .data_sram_wen(data_sram_wen), .data_sram_addr(data_sram_addr),
    .data_sram_wdata(data_sram_wdata)
  );

  task automatic check(input string tag, input logic [75:0] obs, input logic [75:0] expv);
    n_chk++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic push_exp(input string tag, input exp_t e);
    sb.push_back(e);
    tq.push_back(tag);
  endtask

  task automatic step_check();
    exp_t  e;
    string t;
    @(posedge clk); #1;
    e = sb.pop_front();
    t = tq.pop_front();
    check({t, "/mem"},  ex_to_mem_bus, e.mem);
    check({t, "/id"},   {38'b0, ex_to_id_bus}, {38'b0, e.id});
    check({t, "/sram"}, {6'b0, data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata, is_lw},
                        {6'b0, e.sram});
    check({t, "/sreq"}, {75'b0, stallreq_from_ex}, {75'b0, e.sreq});
  endtask

  task automatic issue(input string tag, input logic [31:0] pc, input logic [31:0] inst,
                       input logic [11:0] op, input logic [2:0] s1, input logic [3:0] s2,
                       input logic ren, input logic [3:0] wen, input logic we, input logic [4:0] wa,
                       input logic selr, input logic [31:0] r1, input logic [31:0] r2,
                       input logic [31:0] res, input logic [31:0] addr,
                       input logic exp_we, input logic [4:0] exp_wa);
    exp_t e;
    id_to_ex_bus = {pc, inst, op, s1, s2, ren, wen, we, wa, selr, r1, r2};
    e.mem  = {pc, ren, wen, selr, exp_we, exp_wa, res};
    e.id   = {exp_we, exp_wa, res};
    e.sram = {ren, wen, addr, r2, ren & ~|wen};
    e.sreq = 1'b0;
    last_exp = e;
    push_exp(tag, e);
    step_check();
  endtask

  task automatic mfhi_chk(input string tag, input logic [31:0] expv);
    issue(tag, 32'h0, 32'h0000_1810, 12'h0, 3'b0, 4'b0, 1'b0, 4'h0, 1'b0, 5'd0, 1'b0,
          32'h0, 32'h0, expv, 32'h0, 1'b1, 5'd3);
  endtask

  task automatic mflo_chk(input string tag, input logic [31:0] expv);
    issue(tag, 32'h0, 32'h0000_2012, 12'h0, 3'b0, 4'b0, 1'b0, 4'h0, 1'b0, 5'd0, 1'b0,
          32'h0, 32'h0, expv, 32'h0, 1'b1, 5'd4);
  endtask

  // Div enters EX, then stalled cycles are counted until stallreq drops (DONE cycle).
  task automatic run_div(input string tag, input logic [31:0] inst, input logic [31:0] a,
                         input logic [31:0] b);
    int n = 0;
    id_to_ex_bus = {32'h0, inst, 12'h0, 3'b0, 4'b0, 1'b0, 4'h0, 1'b0, 5'd0, 1'b0, a, b};
    @(posedge clk); #1;
    id_to_ex_bus = '0;
    while (stallreq_from_ex === 1'b1 && n < 200) begin
      n++;
      @(posedge clk); #1;
    end
    check({tag, "/stall_cycles"}, 76'(n), DIV ? 76'd33 : 76'd0);
  endtask

  int          ak[13] = '{11, 10, 9, 8, 7, 6, 5, 4, 3, 2, 1, 0, 12};
  logic [31:0] aa[13] = '{32'h7FFF_FFFF, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hF0F0_F0F0,
                          32'hF0F0_F0F0, 32'hF0F0_F0F0, 32'hF0F0_F0F0, 32'd4, 32'd36, 32'd4,
                          32'd0, 32'h1234_5678};
  logic [31:0] ab[13] = '{32'd1, 32'd5, 32'd1, 32'd1, 32'h0FF0_0FF0, 32'h0FF0_0FF0, 32'h0FF0_0FF0,
                          32'h0FF0_0FF0, 32'h8000_0001, 32'h8000_0000, 32'h8000_0000,
                          32'h0000_1234, 32'h9ABC_DEF0};
  logic [31:0] ar[13] = '{32'h8000_0000, 32'hFFFF_FFFE, 32'd1, 32'd0, 32'h00F0_00F0,
                          32'h000F_000F, 32'hFFF0_FFF0, 32'hFF00_FF00, 32'h0000_0010,
                          32'h0800_0000, 32'hF800_0000, 32'h1234_0000, 32'd0};

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t z;
    logic [11:0] op;
    stall_man    = 6'b0;
    id_to_ex_bus = {159{1'b1}};
    #1 rst = 1'b1;
    z = '0;
    push_exp("reset", z);
    step_check();
    #2 rst = 1'b0;

    // addiu rs=5 imm=-3
    issue("addiu", 32'hBFC0_0010, 32'h2422_FFFD, 12'h800, 3'b001, 4'b0010, 1'b0, 4'h0, 1'b1, 5'd2,
          1'b0, 32'd5, 32'd0, 32'd2, 32'd2, 1'b1, 5'd2);
    issue("sw", 32'hBFC0_0014, 32'hAC22_0008, 12'h800, 3'b001, 4'b0010, 1'b1, 4'hF, 1'b0, 5'd0,
          1'b0, 32'h1000, 32'hAB, 32'h1008, 32'h1008, 1'b0, 5'd0);
    issue("lw", 32'hBFC0_0018, 32'h8C22_0008, 12'h800, 3'b001, 4'b0010, 1'b1, 4'h0, 1'b1, 5'd2,
          1'b1, 32'h1000, 32'h0, 32'h1008, 32'h1008, 1'b1, 5'd2);
    issue("jal_pc8", 32'hBFC0_0020, 32'h0C00_0000, 12'h800, 3'b010, 4'b0100, 1'b0, 4'h0, 1'b1,
          5'd31, 1'b0, 32'h0, 32'h0, 32'hBFC0_0028, 32'hBFC0_0028, 1'b1, 5'd31);
    issue("sll_sa", 32'h0, 32'h0002_18C0, 12'h008, 3'b100, 4'b0001, 1'b0, 4'h0, 1'b1, 5'd3,
          1'b0, 32'h0, 32'h11, 32'h88, 32'h14, 1'b1, 5'd3);
    issue("ori_zext", 32'h0, 32'h3422_8000, 12'h020, 3'b001, 4'b1000, 1'b0, 4'h0, 1'b1, 5'd2,
          1'b0, 32'd1, 32'h0, 32'h8001, 32'h8001, 1'b1, 5'd2);

    for (int i = 0; i < 13; i++) begin
      op = (ak[i] < 12) ? (12'b1 << ak[i]) : 12'b0;
      issue($sformatf("alu%0d", i), 32'h0, 32'h0, op, 3'b001, 4'b0001, 1'b0, 4'h0, 1'b1,
            5'(i + 1), 1'b0, aa[i], ab[i], ar[i], aa[i] + ab[i], 1'b1, 5'(i + 1));
    end

    issue("mthi", 32'h0, 32'h0020_0011, 12'h0, 3'b0, 4'b0, 1'b0, 4'h0, 1'b0, 5'd0, 1'b0,
          32'h1234_5678, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0);
    mfhi_chk("mfhi", 32'h1234_5678);
    issue("mtlo", 32'h0, 32'h0020_0013, 12'h0, 3'b0, 4'b0, 1'b0, 4'h0, 1'b0, 5'd0, 1'b0,
          32'hCAFE_F00D, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0);
    mflo_chk("mflo", 32'hCAFE_F00D);

    run_div("div7_m2", 32'h0022_001A, 32'd7, 32'hFFFF_FFFE);
    mflo_chk("div7_m2_lo", DIV ? 32'hFFFF_FFFD : 32'hCAFE_F00D);
    mfhi_chk("div7_m2_hi", DIV ? 32'd1 : 32'h1234_5678);

    run_div("divu_z", 32'h0022_001B, 32'hFFFF_FFFF, 32'h0);
    mflo_chk("divu_z_lo", DIV ? 32'hFFFF_FFFF : 32'hCAFE_F00D);
    mfhi_chk("divu_z_hi", DIV ? 32'hFFFF_FFFF : 32'h1234_5678);

    // async reset at BUSY cycle 10
    id_to_ex_bus = {32'h0, 32'h0022_001A, 12'h0, 3'b0, 4'b0, 1'b0, 4'h0, 1'b0, 5'd0, 1'b0,
                    32'd100, 32'd7};
    @(posedge clk); #1;
    id_to_ex_bus = '0;
    repeat (11) @(posedge clk);
    #1;
    check("busy10_sreq", {75'b0, stallreq_from_ex}, {75'b0, DIV});
    #2 rst = 1'b1;
    #1;
    check("rst_mid_sreq", {75'b0, stallreq_from_ex}, 76'd0);
    check("rst_mid_mem", ex_to_mem_bus, 76'd0);
    #2 rst = 1'b0;
    mfhi_chk("rst_hi", 32'h0);
    mflo_chk("rst_lo", 32'h0);
    run_div("div100_7", 32'h0022_001A, 32'd100, 32'd7);
    mflo_chk("div100_7_lo", DIV ? 32'd14 : 32'h0);
    mfhi_chk("div100_7_hi", DIV ? 32'd2 : 32'h0);

    // bubble, then hold
    issue("st_ld", 32'hBFC0_0010, 32'h2422_FFFD, 12'h800, 3'b001, 4'b0010, 1'b0, 4'h0, 1'b1, 5'd2,
          1'b0, 32'd5, 32'd0, 32'd2, 32'd2, 1'b1, 5'd2);
    stall_man    = 6'b000100;
    id_to_ex_bus = {32'h1, 32'h8C22_0008, 12'h800, 3'b001, 4'b0010, 1'b1, 4'h0, 1'b1, 5'd9, 1'b1,
                    32'h40, 32'h55};
    push_exp("bubble", z);
    step_check();
    stall_man = 6'b0;
    issue("st_ld2", 32'hBFC0_0010, 32'h2422_FFFD, 12'h800, 3'b001, 4'b0010, 1'b0, 4'h0, 1'b1,
          5'd2, 1'b0, 32'd5, 32'd0, 32'd2, 32'd2, 1'b1, 5'd2);
    stall_man    = 6'b001100;
    id_to_ex_bus = {32'h1, 32'h8C22_0008, 12'h800, 3'b001, 4'b0010, 1'b1, 4'h0, 1'b1, 5'd9, 1'b1,
                    32'h40, 32'h55};
    push_exp("hold", last_exp);
    step_check();
    stall_man = 6'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
